// File: rtl/rs232c_recv_buffer.sv
// rs232c_recv_buffer: 8N1 UART receiver that packs four bytes into a 32-bit
// word (first byte in [31:24]) and queues words in a first-word-fall-through
// FIFO read by the core through a pop interface.
module rs232c_recv_buffer #(
  parameter logic [15:0] WAIT_CYCLES = 16'd5,
  parameter int          DEPTH_LOG2  = 4
) (
  input  logic        clk,
  input  logic        xrst,
  input  logic        rx,
  input  logic        pop,
  output logic [31:0] pop_data,
  output logic        empty,
  output logic        full,
  output logic        overrun,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_e;

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [15:0]       HALF     = WAIT_CYCLES >> 1;
  localparam logic [15:0]       HALF_M1  = HALF - 16'd1;
  localparam logic [15:0]       LAST     = WAIT_CYCLES - 16'd1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  // Receiver state
  state_e      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rxs_q, rxs_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic        push_q, push_d;
  logic        frame_err_q, frame_err_d;

  // FIFO state
  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  push_eff, pop_eff;

  logic at_half, at_last;
  assign at_half = (timer_q == HALF_M1);
  assign at_last = (timer_q == LAST);

  // State register: all control and datapath flops, synchronous reset
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

  // FIFO storage: written only on an effective push
  // NOTE: the word array is not reset; empty masks pop_data so stale contents never show.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= word_q;
  end

  // Next-state logic for the receive FSM
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (!rxs_q) state_d = S_START;
      S_START:   if (at_half) state_d = rxs_q ? S_IDLE : S_DATA;
      S_DATA:    if (at_last && bit_idx_q == 3'd7) state_d = S_STOP;
      S_STOP:    if (at_last) state_d = rxs_q ? S_IDLE : S_RECOVER;
      S_RECOVER: if (rxs_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: synchronizer, bit timer, byte shift and word assembly
  always_comb begin
    rx_meta_d   = rx;
    rxs_d       = rx_meta_q;
    timer_d     = timer_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    push_d      = 1'b0;
    frame_err_d = frame_err_q;
    unique case (state_q)
      S_IDLE: timer_d = '0;
      S_START: begin
        if (at_half) begin
          timer_d   = '0;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (at_last) begin
          timer_d            = '0;
          shift_d[bit_idx_q] = rxs_q;
          bit_idx_d          = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (at_last) begin
          timer_d = '0;
          if (rxs_q) begin
            word_d     = {word_q[23:0], shift_q};
            byte_cnt_d = byte_cnt_q + 2'd1;
            push_d     = (byte_cnt_q == 2'd3);
          end else begin
            // Broken frame: the whole partial word is abandoned
            frame_err_d = 1'b1;
            word_d      = '0;
            byte_cnt_d  = '0;
          end
        end
      end
      S_RECOVER: timer_d = '0;
      default:   timer_d = '0;
    endcase
  end

  // FIFO pointer/count update; push and pop both take effect when legal
  always_comb begin
    pop_eff   = pop && (count_q != '0);
    push_eff  = push_q && ((count_q != CNT_FULL) || pop_eff);
    overrun_d = overrun_q | (push_q & ~push_eff);
    wr_ptr_d  = push_eff ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = pop_eff  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d   = count_q;
    if (push_eff && !pop_eff) count_d = count_q + CNT_ONE;
    if (!push_eff && pop_eff) count_d = count_q - CNT_ONE;
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign pop_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rs232c_recv_buffer.sv
// Testbench for rs232c_recv_buffer: drives 8N1 frames at 5 clk/bit and
// compares FIFO outputs and sticky flags against a queue-based model.
module tb_rs232c_recv_buffer;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic        rx = 1'b1;
  logic        pop = 1'b0;
  logic [31:0] pop_data;
  logic        empty, full, overrun, frame_err;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: words the receiver should hold, plus sticky flags
  logic [31:0] exp_q [$];
  logic        exp_overrun = 1'b0;
  logic        exp_frame_err = 1'b0;
  localparam int MODEL_DEPTH = 16;

  rs232c_recv_buffer #(.WAIT_CYCLES(16'd5), .DEPTH_LOG2(4)) dut (
    .clk(clk), .xrst(xrst), .rx(rx), .pop(pop), .pop_data(pop_data),
    .empty(empty), .full(full), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One serial bit lasts 5 clocks
  task automatic send_bit(input logic b);
    rx = b;
    idle(5);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  // Send a word as 4 bytes, MSB byte first, and record it in the model
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
    if (exp_q.size() < MODEL_DEPTH) exp_q.push_back(w);
    else exp_overrun = 1'b1;
    idle(3);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] head;
    head = (exp_q.size() == 0) ? 32'h0 : exp_q[0];
    check({tag, "_empty"},     {31'd0, empty},     {31'd0, exp_q.size() == 0});
    check({tag, "_full"},      {31'd0, full},      {31'd0, exp_q.size() == MODEL_DEPTH});
    check({tag, "_overrun"},   {31'd0, overrun},   {31'd0, exp_overrun});
    check({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, exp_frame_err});
    check({tag, "_pop_data"},  pop_data,           head);
  endtask

  // Compare the head against the model, then pop it
  task automatic pop_check(input string tag);
    logic [31:0] want;
    want = (exp_q.size() == 0) ? 32'h0 : exp_q.pop_front();
    check(tag, pop_data, want);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  initial begin
    logic [31:0] w;

    // Reset
    idle(3);
    check_status("reset");
    xrst = 1'b1;
    idle(4);
    check_status("after_reset");

    // 1: directed word, latency on empty
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    idle(2);
    check("latency_empty", {31'd0, empty}, 32'd0);
    exp_q.push_back(32'h12345678);
    check_status("word1");
    pop_check("pop_word1");
    check_status("after_pop1");

    // 2: three random words in order
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      send_word(w);
    end
    check_status("rand3");
    for (int i = 0; i < 3; i++) pop_check($sformatf("pop_rand_%0d", i));
    check_status("rand3_drained");

    // 3: fill to full, then overflow by one word
    for (int i = 0; i < 16; i++) send_word($urandom);
    check_status("filled");
    send_word($urandom);
    check_status("overflowed");
    for (int i = 0; i < 16; i++) pop_check($sformatf("pop_fill_%0d", i));
    check_status("fill_drained");

    // 4: one-clock glitch is ignored, then a normal word
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    idle(20);
    check_status("glitch");
    send_word($urandom);
    check_status("after_glitch");
    pop_check("pop_after_glitch");

    // 5: bad stop bit on the second byte drops the partial word
    send_byte(8'ha5, 1'b1);
    send_byte(8'h3c, 1'b0);
    exp_frame_err = 1'b1;
    idle(10);
    check_status("frame_err");
    send_word(32'h11112222);
    check_status("after_frame_err");
    pop_check("pop_11112222");

    // 6: reset during bit 3 of byte 2 with a word queued and flags set
    send_word($urandom);
    send_byte(8'h5a, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b0;
    idle(2);
    xrst = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    xrst = 1'b1;
    exp_q.delete();
    exp_overrun = 1'b0;
    exp_frame_err = 1'b0;
    check_status("mid_frame_reset");
    idle(10);
    check_status("post_reset_idle");
    send_word(32'heee80a0e);
    check_status("after_reset_word");
    pop_check("pop_eee80a0e");
    check_status("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
